trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
// - Sequences precise traps, interrupts and MRET at writeback. Exceptions travel down the pipe as pending bits and are acted on only at writeback.
// - Samples the writeback-stage pending bits, arbitrates exception > mret > interrupt, and drives the CSR file trap-write strobe and the pipeline flush.
// - Then issues a single-cycle PC redirect to fetch.
// - Sits between the writeback stage, the CSR file and the fetch stage.
// PARAMETERS
// - FLUSH_CYCLES  2  cycles controlReset is held high; legal range 1..15.
// - SYNC_STAGES   2  flop stages on the asynchronous interrupt line; legal range 2..4.
// PORTS
// - clock            in   1   system clock; all state updates on posedge.
// - reset            in   1   synchronous, active-high.
// - interrupt        in   1   external machine interrupt, asynchronous, level.
// - mieEnable        in   1   mstatus.MIE from the CSR file.
// - mtvec            in   32  trap vector from the CSR file.
// - mepc             in   32  exception PC from the CSR file.
// - wbValid          in   1   writeback stage holds a valid instruction.
// - wbExcPending     in   1   that instruction carries a pending exception.
// - wbExcCause       in   4   exception code.
// - wbExcTval        in   32  faulting address or instruction.
// - wbIsMret         in   1   that instruction is MRET.
// - wbPC             in   32  PC of the writeback instruction.
// - retireKill       out  1   combinational; suppresses retire and minstret for the writeback instruction.
// - controlReset     out  1   pipeline flush; also the CSR trap-write strobe.
// - trapCause        out  4   latched cause to CSR mcause.
// - trapInterrupt    out  1   latched; 1 = interrupt trap (mcause bit 31).
// - trapTval         out  32  latched value to CSR mtval.
// - trapEpc          out  32  latched value to CSR mepc.
// - mretCommit       out  1   one-cycle pulse; CSR file restores MIE.
// - redirectValid    out  1   one-cycle fetch redirect.
// - redirectPC       out  32  redirect target.
// - busy             out  1   state != IDLE; fetch stalls.
// BEHAVIOUR
// - Reset: state = IDLE. All outputs 0. Sync chain cleared. Flush counter 0. Reset mid-sequence aborts with no redirect.
// - irqSync = last flop of the SYNC_STAGES chain. irqTake = irqSync & mieEnable.
// - Event in IDLE, cycle N. Priority when wbValid:
//   - wbExcPending -> EXC.
//   - else wbIsMret -> MRET.
//   - else irqTake -> IRQ.
//   - No event -> stay IDLE.
// - retireKill=1 in cycle N for EXC and IRQ; retireKill=0 for MRET.
// - Cycle N+1 enters FLUSH. Latched values:
//   - EXC: cause = wbExcCause, tval = wbExcTval, epc = wbPC, trapInterrupt = 0.
//   - IRQ: cause = 4'd11, tval = 0, epc = wbPC, trapInterrupt = 1. The interrupted instruction re-executes after MRET.
//   - MRET: cause, tval and epc are not updated; mretCommit pulses in cycle N+1 only.
// - FLUSH: controlReset=1 for exactly FLUSH_CYCLES cycles, counted by a 4-bit down-counter. CSR trap-write fires once, at the rising edge of controlReset. Then go to REDIRECT.
// - REDIRECT lasts 1 cycle: redirectValid=1.
//   - Trap: redirectPC = {mtvec[31:2],2'b00}; direct mode only.
//   - MRET: redirectPC = mepc, sampled this cycle.
//   - Next state IDLE.
// - While busy, all wb* inputs are ignored. Flushed instructions never raise a second event.
// - Interrupt asserted during FLUSH or REDIRECT is held by the level input. It is taken at the first valid wb instruction after IDLE, if still enabled.
// - Interrupt without wbValid is not taken; it waits for an instruction boundary.
// - Simultaneous exception and interrupt in cycle N: exception wins and the interrupt stays pending.
// - Back-to-back: the earliest next event is cycle N+FLUSH_CYCLES+2.
// STRUCTURE
// - Shared package pack:
//   - typedef trapState_ {IDLE, FLUSH, REDIRECT}.
//   - typedef trapKind_ {EXC, MRET, IRQ}.
//   - constant MCAUSE_MEI = 4'd11.
// - Sub-module sync_flops (parameter STAGES): generic synchroniser, reusable elsewhere.
// - Everything else is flat: one FSM block plus one output-register block.
// TESTING
// - Illegal instruction: wbValid=1, wbExcPending=1, cause=2, tval=32'h0000_0073, wbPC=32'h100, mtvec=32'h200.
//   - retireKill=1 in N. controlReset high N+1..N+2. trapEpc=32'h100, trapCause=2.
//   - redirectPC=32'h200 at N+3.
// - MRET with mepc=32'h104: retireKill=0, mretCommit pulses at N+1, trapCause unchanged, redirectPC=32'h104 at N+3.
// - Interrupt with mieEnable=1, wbValid=1, wbPC=32'h180: taken after the SYNC_STAGES delay.
//   - trapInterrupt=1, trapCause=11, trapEpc=32'h180, trapTval=0.
//   - With mieEnable=0 there is no event.
// - Exception and interrupt in the same cycle: exception taken first, then the interrupt at the first valid instruction after IDLE.
// - wb activity during FLUSH, with wbExcPending toggling: no second controlReset pulse and no extra redirect.
// - reset asserted on cycle N+2 (mid-FLUSH): next cycle all outputs 0, state IDLE, no redirectValid.

Source files
------------

// File: rtl/trap_controller_pkg.sv
// trap_controller_pkg: shared FSM state, trap kind and cause encodings for the trap controller
package trap_controller_pkg;
   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} trap_state_e;
   typedef enum logic [1:0] {EXC, MRET, IRQ} trap_kind_e;
   localparam logic [3:0] MCAUSE_MEI = 4'd11;
   function automatic logic [31:0] trap_vector(input logic [31:0] base);
      return base & 32'hFFFF_FFFC;
   endfunction
endpackage

// File: rtl/trap_controller_sync_flops.sv
// sync_flops: generic multi-flop synchroniser for a single asynchronous level signal
module sync_flops #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] chain;
   // shift the asynchronous level through the chain; reset clears every stage
   always_ff @(posedge clock)
      chain <= reset ? '0 : {chain[STAGES-2:0], d};
   assign q = chain[STAGES-1];
endmodule

// File: rtl/trap_controller.sv
// trap_controller: writeback-stage trap/interrupt/MRET sequencer driving CSR writes, flush and fetch redirect
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        interrupt,
   input  logic        mieEnable,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   input  logic        wbValid,
   input  logic        wbExcPending,
   input  logic [3:0]  wbExcCause,
   input  logic [31:0] wbExcTval,
   input  logic        wbIsMret,
   input  logic [31:0] wbPC,
   output logic        retireKill,
   output logic        controlReset,
   output logic [3:0]  trapCause,
   output logic        trapInterrupt,
   output logic [31:0] trapTval,
   output logic [31:0] trapEpc,
   output logic        mretCommit,
   output logic        redirectValid,
   output logic [31:0] redirectPC,
   output logic        busy
);
   trap_state_e state;
   trap_kind_e  kind;
   trap_kind_e  next_kind;
   logic [3:0]  count;
   logic        irq_sync;
   logic        irq_take;
   logic        take;

   sync_flops #(.STAGES(SYNC_STAGES)) u_sync (
      .clock(clock),
      .reset(reset),
      .d(interrupt),
      .q(irq_sync)
   );

   assign irq_take      = irq_sync & mieEnable;
   assign take          = state == IDLE && wbValid && (wbExcPending || wbIsMret || irq_take);
   assign next_kind     = wbExcPending ? EXC : wbIsMret ? MRET : IRQ;
   assign retireKill    = take && next_kind != MRET;
   assign busy          = state != IDLE;
   assign controlReset  = state == FLUSH;
   assign redirectValid = state == REDIRECT;
   assign redirectPC    = redirectValid ? (kind == MRET ? mepc : trap_vector(mtvec)) : '0;

   // sequence IDLE -> FLUSH (held FLUSH_CYCLES cycles) -> REDIRECT -> IDLE
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         kind  <= EXC;
      end else begin
         case (state)
            IDLE:
               if (take) begin
                  state <= FLUSH;
                  count <= 4'(FLUSH_CYCLES);
                  kind  <= next_kind;
               end
            FLUSH: begin
               count <= count - 4'd1;
               if (count == 4'd1) state <= REDIRECT;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // latch trap CSR values on a trap event and pulse mretCommit on MRET
   always_ff @(posedge clock) begin
      if (reset) begin
         mretCommit    <= 1'b0;
         trapCause     <= '0;
         trapInterrupt <= 1'b0;
         trapTval      <= '0;
         trapEpc       <= '0;
      end else begin
         mretCommit <= take && next_kind == MRET;
         if (take && next_kind != MRET) begin
            trapCause     <= next_kind == EXC ? wbExcCause : MCAUSE_MEI;
            trapInterrupt <= next_kind == IRQ;
            trapTval      <= next_kind == EXC ? wbExcTval : '0;
            trapEpc       <= wbPC;
         end
      end
   end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: vector table, directed corner cases and random traffic against a timeline model
module tb_trap_controller;
   localparam int FC = 2;
   localparam int S  = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        interrupt = 1'b0;
   logic        mieEnable = 1'b0;
   logic [31:0] mtvec = '0;
   logic [31:0] mepc = '0;
   logic        wbValid = 1'b0;
   logic        wbExcPending = 1'b0;
   logic [3:0]  wbExcCause = '0;
   logic [31:0] wbExcTval = '0;
   logic        wbIsMret = 1'b0;
   logic [31:0] wbPC = '0;
   logic        retireKill, controlReset, trapInterrupt, mretCommit, redirectValid, busy;
   logic [3:0]  trapCause;
   logic [31:0] trapTval, trapEpc, redirectPC;

   trap_controller #(.FLUSH_CYCLES(FC), .SYNC_STAGES(S)) dut (
      .clock(clock), .reset(reset), .interrupt(interrupt), .mieEnable(mieEnable),
      .mtvec(mtvec), .mepc(mepc), .wbValid(wbValid), .wbExcPending(wbExcPending),
      .wbExcCause(wbExcCause), .wbExcTval(wbExcTval), .wbIsMret(wbIsMret), .wbPC(wbPC),
      .retireKill(retireKill), .controlReset(controlReset), .trapCause(trapCause),
      .trapInterrupt(trapInterrupt), .trapTval(trapTval), .trapEpc(trapEpc),
      .mretCommit(mretCommit), .redirectValid(redirectValid), .redirectPC(redirectPC),
      .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic v, e, m, i, ie, rk;
      int   kind;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          m_ev = -1000;
   int          m_kind = 0;
   logic [3:0]  m_cause = '0;
   logic        m_intr = 1'b0;
   logic [31:0] m_tval = '0;
   logic [31:0] m_epc = '0;
   logic        irq_q[$];
   vec_t        vecs[9];
   int          rises, redirs;
   logic        prev_cr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_ev = -1000;
      m_kind = 0;
      m_cause = '0;
      m_intr = 1'b0;
      m_tval = '0;
      m_epc = '0;
      irq_q.delete();
   endtask

   task automatic idle_inputs();
      wbValid = 1'b0;
      wbExcPending = 1'b0;
      wbIsMret = 1'b0;
   endtask

   // one cycle: compare DUT against the event timeline at negedge, then advance the model
   task automatic step();
      int   p;
      logic bz, sync, ev;
      @(negedge clock);
      p    = cyc - m_ev;
      bz   = p >= 1 && p <= FC + 1;
      sync = irq_q.size() >= S ? irq_q[irq_q.size() - S] : 1'b0;
      ev   = !bz && wbValid && (wbExcPending || wbIsMret || (sync && mieEnable));
      chk("retireKill", retireKill, ev && (wbExcPending || !wbIsMret));
      chk("busy", busy, bz);
      chk("controlReset", controlReset, p >= 1 && p <= FC);
      chk("redirectValid", redirectValid, p == FC + 1);
      chk("redirectPC", redirectPC, p == FC + 1 ? (m_kind == 1 ? mepc : mtvec & ~32'h3) : 32'h0);
      chk("mretCommit", mretCommit, p == 1 && m_kind == 1);
      chk("trapCause", trapCause, m_cause);
      chk("trapInterrupt", trapInterrupt, m_intr);
      chk("trapTval", trapTval, m_tval);
      chk("trapEpc", trapEpc, m_epc);
      if (reset) model_reset();
      else begin
         if (ev) begin
            m_ev = cyc;
            m_kind = wbExcPending ? 0 : wbIsMret ? 1 : 2;
            if (m_kind != 1) begin
               m_cause = m_kind == 0 ? wbExcCause : 4'd11;
               m_intr  = m_kind == 2;
               m_tval  = m_kind == 0 ? wbExcTval : 32'h0;
               m_epc   = wbPC;
            end
         end
         irq_q.push_back(interrupt);
         if (irq_q.size() > S) void'(irq_q.pop_front());
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      do_reset();
      chk("rst_controlReset", controlReset, 0);
      chk("rst_busy", busy, 0);
      chk("rst_redirectValid", redirectValid, 0);
      chk("rst_redirectPC", redirectPC, 0);
      chk("rst_mretCommit", mretCommit, 0);
      chk("rst_trapCause", trapCause, 0);
      chk("rst_trapInterrupt", trapInterrupt, 0);
      chk("rst_trapTval", trapTval, 0);
      chk("rst_trapEpc", trapEpc, 0);
      chk("rst_retireKill", retireKill, 0);

      // kind: 0 exc, 1 mret, 2 irq, 3 none
      vecs[0] = '{1, 0, 0, 0, 1, 0, 3};
      vecs[1] = '{1, 1, 0, 0, 1, 1, 0};
      vecs[2] = '{1, 0, 1, 0, 1, 0, 1};
      vecs[3] = '{1, 0, 0, 1, 1, 1, 2};
      vecs[4] = '{1, 0, 0, 1, 0, 0, 3};
      vecs[5] = '{0, 1, 1, 1, 1, 0, 3};
      vecs[6] = '{1, 1, 1, 1, 1, 1, 0};
      vecs[7] = '{1, 0, 1, 1, 1, 0, 1};
      vecs[8] = '{1, 1, 0, 1, 1, 1, 0};
      for (int k = 0; k < 9; k++) begin
         do_reset();
         interrupt = vecs[k].i;
         mieEnable = vecs[k].ie;
         repeat (S) step();
         wbValid = vecs[k].v;
         wbExcPending = vecs[k].e;
         wbIsMret = vecs[k].m;
         wbExcCause = 4'd7;
         wbExcTval = 32'h55;
         wbPC = 32'h400 + 32'(k * 4);
         #1 chk("tbl_retireKill", retireKill, vecs[k].rk);
         step();
         chk("tbl_flush", controlReset, vecs[k].kind != 3);
         chk("tbl_mret", mretCommit, vecs[k].kind == 1);
         chk("tbl_intr", trapInterrupt, vecs[k].kind == 2);
         chk("tbl_cause", trapCause, vecs[k].kind == 0 ? 7 : vecs[k].kind == 2 ? 11 : 0);
         idle_inputs();
         interrupt = 1'b0;
         repeat (FC + 3) step();
      end

      // illegal instruction, then MRET
      do_reset();
      mtvec = 32'h200;
      wbValid = 1'b1; wbExcPending = 1'b1; wbExcCause = 4'd2; wbExcTval = 32'h73; wbPC = 32'h100;
      #1 chk("ill_retireKill", retireKill, 1);
      step();
      idle_inputs();
      chk("ill_cr_n1", controlReset, 1);
      chk("ill_epc", trapEpc, 32'h100);
      chk("ill_cause", trapCause, 2);
      chk("ill_tval", trapTval, 32'h73);
      step();
      chk("ill_cr_n2", controlReset, 1);
      step();
      chk("ill_cr_n3", controlReset, 0);
      chk("ill_redir", redirectValid, 1);
      chk("ill_redirPC", redirectPC, 32'h200);
      step();
      chk("ill_redir_done", redirectValid, 0);
      mepc = 32'h104;
      wbValid = 1'b1; wbIsMret = 1'b1;
      #1 chk("mret_retireKill", retireKill, 0);
      step();
      idle_inputs();
      chk("mret_commit_n1", mretCommit, 1);
      chk("mret_cause_kept", trapCause, 2);
      step();
      chk("mret_commit_n2", mretCommit, 0);
      step();
      chk("mret_redirPC", redirectPC, 32'h104);
      step();

      // interrupt through the synchroniser, then disabled interrupt
      mieEnable = 1'b1; interrupt = 1'b1; wbValid = 1'b1; wbPC = 32'h180;
      for (int i = 0; i < S; i++) begin
         #1 chk("irq_wait", retireKill, 0);
         step();
      end
      #1 chk("irq_take", retireKill, 1);
      step();
      idle_inputs();
      interrupt = 1'b0;
      chk("irq_intr", trapInterrupt, 1);
      chk("irq_cause", trapCause, 11);
      chk("irq_epc", trapEpc, 32'h180);
      chk("irq_tval", trapTval, 0);
      repeat (FC + 3) step();
      mieEnable = 1'b0; interrupt = 1'b1; wbValid = 1'b1;
      for (int i = 0; i < S + 2; i++) begin
         #1 chk("irq_masked", retireKill, 0);
         step();
      end
      idle_inputs();
      interrupt = 1'b0;
      repeat (S + 1) step();

      // exception and interrupt together: exception first, interrupt after IDLE
      mieEnable = 1'b1; interrupt = 1'b1;
      repeat (S) step();
      wbValid = 1'b1; wbExcPending = 1'b1; wbExcCause = 4'd5; wbPC = 32'h300;
      step();
      chk("both_exc_intr", trapInterrupt, 0);
      chk("both_exc_cause", trapCause, 5);
      wbExcPending = 1'b0; wbPC = 32'h304;
      repeat (FC + 1) step();
      #1 chk("both_irq_take", retireKill, 1);
      step();
      chk("both_irq_intr", trapInterrupt, 1);
      chk("both_irq_epc", trapEpc, 32'h304);
      idle_inputs();
      interrupt = 1'b0;
      repeat (FC + 3) step();

      // wb activity while busy raises no second event
      rises = 0; redirs = 0; prev_cr = 1'b0;
      wbValid = 1'b1; wbExcPending = 1'b1; wbPC = 32'h500;
      for (int i = 0; i < FC + 6; i++) begin
         step();
         if (i < FC) wbExcPending = ~wbExcPending;
         else idle_inputs();
         if (controlReset && !prev_cr) rises++;
         if (redirectValid) redirs++;
         prev_cr = controlReset;
      end
      chk("busy_rises", rises, 1);
      chk("busy_redirs", redirs, 1);

      // reset in the middle of FLUSH
      wbValid = 1'b1; wbExcPending = 1'b1; wbExcCause = 4'd4; wbPC = 32'h600;
      step();
      idle_inputs();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_cr", controlReset, 0);
      chk("mid_busy", busy, 0);
      chk("mid_cause", trapCause, 0);
      chk("mid_epc", trapEpc, 0);
      redirs = 0;
      repeat (3) begin
         if (redirectValid) redirs++;
         step();
      end
      chk("mid_no_redirect", redirs, 0);

      // random traffic
      do_reset();
      repeat (3000) begin
         reset = $urandom_range(0, 299) == 0;
         if ($urandom_range(0, 19) == 0) interrupt = ~interrupt;
         mieEnable = $urandom_range(0, 3) != 0;
         wbValid = $urandom_range(0, 9) < 7;
         wbExcPending = $urandom_range(0, 4) == 0;
         wbIsMret = $urandom_range(0, 5) == 0;
         wbExcCause = 4'($urandom);
         wbExcTval = $urandom;
         wbPC = $urandom;
         mtvec = $urandom;
         mepc = $urandom;
         step();
      end
      reset = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
